// File: rtl/hdmi_cap_pkg.sv
// Shared definitions for the HDMI frame-capture path.
//
// Contents:
//   ADDR_W_DEF, FRAME_PIXELS_DEF, FID_W_DEF - default sizing for a 480x270 frame.
//   ST_*                                     - capture controller state encodings.
//   frame_held()                             - true while a finished frame occupies the buffer.

package hdmi_cap_pkg;

    localparam int unsigned ADDR_W_DEF       = 24;
    localparam int unsigned FRAME_PIXELS_DEF = 129600;
    localparam int unsigned FID_W_DEF        = 8;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_VS = 3'd1;
    localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd2;
    localparam logic [STATE_W-1:0] ST_READY   = 3'd3;
    localparam logic [STATE_W-1:0] ST_TX      = 3'd4;

    // A completed frame sits in the buffer from READY until TX releases it.
    function automatic logic frame_held(input logic [STATE_W-1:0] st);
        return (st == ST_READY) || (st == ST_TX);
    endfunction

endpackage

// File: rtl/edge_det.sv
// Registered rising-edge detector.
//
// Ports:
//   clk   - clock
//   rstb  - synchronous active-low reset; loads the history flop with RST_VAL
//   sig   - level input
//   rise  - high for the cycle where sig is 1 and was 0 on the previous cycle
//
// A RST_VAL of 1 suppresses a false edge when sig is already high at reset release.

module edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstb,
    input  logic sig,
    output logic rise
);

    logic sig_d;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            sig_d <= RST_VAL;
        end else begin
            sig_d <= sig;
        end
    end

    assign rise = sig & ~sig_d;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame capture controller: writes one downscaled frame into the shared frame BRAM,
// then hands the buffer to the Ethernet TX packetizer by request/grant.
//
// Ports:
//   clk, rstb                  - clock, synchronous active-low reset
//   i_arm                      - level; keep capturing while high, stop after the current handoff
//   i_vsync                    - vertical sync; a rising edge opens/closes a frame
//   i_ena, i_addr, i_rgb       - pixel stream from the downscaler
//   o_we, o_waddr, o_wdata     - registered BRAM write port (addr/data hold while o_we=0)
//   i_tx_req, o_tx_grant       - TX buffer request / ownership
//   i_tx_done                  - one-cycle pulse, TX finished reading
//   o_frame_valid              - a captured frame is waiting for / owned by TX
//   o_short                    - the last frame ended on vsync before FRAME_PIXELS pixels
//   o_addr_err                 - sticky, an out-of-range pixel address was seen while capturing
//   o_frame_id                 - count of completed handoffs (wraps)
//   o_drop_cnt                 - only with FRAME_CAPTURE_DROP_CNT_EN: saturating count of
//                                vsync edges that arrived while the buffer was held
//
// Optional feature macro: FRAME_CAPTURE_DROP_CNT_EN.

module frame_capture_ctrl
    import hdmi_cap_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter int unsigned FID_W        = FID_W_DEF
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              i_arm,
    input  logic              i_vsync,
    input  logic              i_ena,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [23:0]       i_rgb,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [23:0]       o_wdata,
    input  logic              i_tx_req,
    output logic              o_tx_grant,
    input  logic              i_tx_done,
    output logic              o_frame_valid,
    output logic              o_short,
    output logic              o_addr_err,
    output logic [FID_W-1:0]  o_frame_id
`ifdef FRAME_CAPTURE_DROP_CNT_EN
    ,
    output logic [15:0]       o_drop_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(FRAME_PIXELS + 1);

    localparam logic [CNT_W-1:0]  FRAME_CNT  = CNT_W'(FRAME_PIXELS);
    localparam logic [ADDR_W-1:0] FRAME_ADDR = ADDR_W'(FRAME_PIXELS);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               short_q, short_d;
    logic               addr_err_q, addr_err_d;
    logic [FID_W-1:0]   fid_q, fid_d;

    logic               we_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [23:0]        wdata_q;

    logic               vs_rise;
    logic               pix_in_range;
    logic               pix_ok;
    logic               accept;

    // Reset value 1: a vsync already high at reset release must not start a frame.
    edge_det #(
        .RST_VAL (1'b1)
    ) u_vs_edge (
        .clk  (clk),
        .rstb (rstb),
        .sig  (i_vsync),
        .rise (vs_rise)
    );

    assign cnt_inc      = cnt_q + CNT_W'(1);
    assign pix_in_range = (i_addr < FRAME_ADDR);
    assign pix_ok       = i_ena & pix_in_range;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        short_d    = short_q;
        addr_err_d = addr_err_q;
        fid_d      = fid_q;
        accept     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_arm) begin
                    state_d = ST_WAIT_VS;
                end
            end

            ST_WAIT_VS: begin
                if (vs_rise) begin
                    cnt_d   = '0;
                    short_d = 1'b0;
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                if (i_ena && !pix_in_range) begin
                    addr_err_d = 1'b1;
                end
                // A pixel that completes the frame in the same cycle as vsync still counts,
                // making it a full frame; any other pixel alongside vsync is dropped.
                if (pix_ok && (!vs_rise || (cnt_inc == FRAME_CNT))) begin
                    accept = 1'b1;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == FRAME_CNT) begin
                        state_d = ST_READY;
                    end
                end else if (vs_rise) begin
                    short_d = 1'b1;
                    state_d = ST_READY;
                end
            end

            ST_READY: begin
                if (i_tx_req) begin
                    state_d = ST_TX;
                end
            end

            ST_TX: begin
                if (i_tx_done) begin
                    fid_d   = fid_q + FID_W'(1);
                    state_d = i_arm ? ST_WAIT_VS : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            short_q    <= 1'b0;
            addr_err_q <= 1'b0;
            fid_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            short_q    <= short_d;
            addr_err_q <= addr_err_d;
            fid_q      <= fid_d;
        end
    end

    // Write port: address/data only load on an accepted pixel so they hold otherwise.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= accept;
            if (accept) begin
                waddr_q <= i_addr;
                wdata_q <= i_rgb;
            end
        end
    end

`ifdef FRAME_CAPTURE_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    // A vsync edge while the buffer is held means that frame could not be captured.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            drop_cnt_q <= '0;
        end else if (vs_rise && frame_held(state_q) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`endif

    assign o_we          = we_q;
    assign o_waddr       = waddr_q;
    assign o_wdata       = wdata_q;
    assign o_tx_grant    = (state_q == ST_TX);
    assign o_frame_valid = frame_held(state_q);
    assign o_short       = short_q;
    assign o_addr_err    = addr_err_q;
    assign o_frame_id    = fid_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Self-checking bench for frame_capture_ctrl: scripted scenarios plus a randomized run,
// every cycle compared against a behavioural model of the capture/handoff rules.
// Uses a small frame (64 pixels) and a 3-bit frame id so wrap-around is reached quickly.

module tb_frame_capture_ctrl;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned FP     = 64;
    localparam int unsigned FID_W  = 3;

    logic              clk = 1'b0;
    logic              rstb = 1'b0;
    logic              i_arm = 1'b0;
    logic              i_vsync = 1'b0;
    logic              i_ena = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [23:0]       i_rgb = '0;
    logic              i_tx_req = 1'b0;
    logic              i_tx_done = 1'b0;
    logic              o_we;
    logic [ADDR_W-1:0] o_waddr;
    logic [23:0]       o_wdata;
    logic              o_tx_grant;
    logic              o_frame_valid;
    logic              o_short;
    logic              o_addr_err;
    logic [FID_W-1:0]  o_frame_id;
`ifdef FRAME_CAPTURE_DROP_CNT_EN
    logic [15:0]       o_drop_cnt;
`endif

    frame_capture_ctrl #(
        .ADDR_W       (ADDR_W),
        .FRAME_PIXELS (FP),
        .FID_W        (FID_W)
    ) dut (
        .clk           (clk),
        .rstb          (rstb),
        .i_arm         (i_arm),
        .i_vsync       (i_vsync),
        .i_ena         (i_ena),
        .i_addr        (i_addr),
        .i_rgb         (i_rgb),
        .o_we          (o_we),
        .o_waddr       (o_waddr),
        .o_wdata       (o_wdata),
        .i_tx_req      (i_tx_req),
        .o_tx_grant    (o_tx_grant),
        .i_tx_done     (i_tx_done),
        .o_frame_valid (o_frame_valid),
        .o_short       (o_short),
        .o_addr_err    (o_addr_err),
        .o_frame_id    (o_frame_id)
`ifdef FRAME_CAPTURE_DROP_CNT_EN
        ,
        .o_drop_cnt    (o_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int writes_seen = 0;

    // Behavioural model: which phase of the frame lifecycle we are in, and what the
    // outputs must look like after the next clock edge.
    typedef enum int {PhIdle, PhWait, PhCapture, PhHeld, PhOwned} phase_t;
    phase_t      m_phase = PhIdle;
    bit          m_vs_prev = 1'b1;
    int          m_count = 0;
    bit          m_we = 1'b0;
    int unsigned m_waddr = 0;
    int unsigned m_wdata = 0;
    bit          m_short = 1'b0;
    bit          m_err = 1'b0;
    int unsigned m_fid = 0;
    int unsigned m_drop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("we", 32'(o_we), 32'(m_we));
        if (m_we) begin
            chk("waddr", 32'(o_waddr), m_waddr);
            chk("wdata", 32'(o_wdata), m_wdata);
        end else begin
            // Held values must not change while no write is issued.
            chk("waddr_hold", 32'(o_waddr), m_waddr);
            chk("wdata_hold", 32'(o_wdata), m_wdata);
        end
        chk("grant", 32'(o_tx_grant), 32'(m_phase == PhOwned));
        chk("frame_valid", 32'(o_frame_valid), 32'(m_phase == PhHeld || m_phase == PhOwned));
        chk("short", 32'(o_short), 32'(m_short));
        chk("addr_err", 32'(o_addr_err), 32'(m_err));
        chk("frame_id", 32'(o_frame_id), m_fid);
`ifdef FRAME_CAPTURE_DROP_CNT_EN
        chk("drop_cnt", 32'(o_drop_cnt), m_drop);
`endif
        if (o_we === 1'b1) writes_seen++;
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input bit rst, input bit arm, input bit vs, input bit ena,
                              input int unsigned addr, input int unsigned rgb,
                              input bit req, input bit done);
        bit rise;
        bit take;
        rise = vs && !m_vs_prev;
        m_we = 1'b0;
        if (rst) begin
            m_phase = PhIdle; m_vs_prev = 1'b1; m_count = 0;
            m_waddr = 0; m_wdata = 0; m_short = 0; m_err = 0; m_fid = 0; m_drop = 0;
            return;
        end
        m_vs_prev = vs;
        if (rise && (m_phase == PhHeld || m_phase == PhOwned) && m_drop < 65535) m_drop++;
        case (m_phase)
            PhIdle: if (arm) m_phase = PhWait;
            PhWait: if (rise) begin
                m_count = 0; m_short = 0; m_phase = PhCapture;
            end
            PhCapture: begin
                if (ena && addr >= FP) m_err = 1;
                take = ena && addr < FP && (!rise || m_count == FP - 1);
                if (take) begin
                    m_we = 1; m_waddr = addr; m_wdata = rgb; m_count++;
                    if (m_count == FP) m_phase = PhHeld;
                end else if (rise) begin
                    m_short = 1; m_phase = PhHeld;
                end
            end
            PhHeld: if (req) m_phase = PhOwned;
            PhOwned: if (done) begin
                m_fid = (m_fid + 1) % (1 << FID_W);
                m_phase = arm ? PhWait : PhIdle;
            end
            default: m_phase = PhIdle;
        endcase
    endtask

    // One cycle: check outputs away from the active edge, then drive the next inputs.
    task automatic cyc(input bit rst, input bit arm, input bit vs, input bit ena,
                       input int unsigned addr, input int unsigned rgb,
                       input bit req, input bit done);
        @(negedge clk);
        compare_all();
        rstb      = !rst;
        i_arm     = arm;
        i_vsync   = vs;
        i_ena     = ena;
        i_addr    = ADDR_W'(addr);
        i_rgb     = 24'(rgb);
        i_tx_req  = req;
        i_tx_done = done;
        model_step(rst, arm, vs, ena, addr, rgb, req, done);
    endtask

    task automatic idle(input bit arm, input bit vs, input int n);
        for (int k = 0; k < n; k++) cyc(0, arm, vs, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit vs_lvl;
        bit arm_lvl;

        // Reset.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 1);
        chk("lit_reset_fid", 32'(o_frame_id), 32'd0);
        chk("lit_reset_valid", 32'(o_frame_valid), 32'd0);
        chk("lit_reset_we", 32'(o_we), 32'd0);

        // Full frame.
        idle(1, 0, 2);
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        writes_seen = 0;
        for (int p = 0; p < FP; p++) cyc(0, 1, 0, 1, p, $urandom & 24'hFFFFFF, 0, 0);
        idle(1, 0, 1);
        chk("lit_full_writes", 32'(writes_seen), FP);
        chk("lit_full_valid", 32'(o_frame_valid), 32'd1);
        chk("lit_full_short", 32'(o_short), 32'd0);

        // Handshake, pixels during TX discarded.
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        idle(1, 0, 1);
        chk("lit_grant", 32'(o_tx_grant), 32'd1);
        writes_seen = 0;
        for (int p = 0; p < 5; p++) cyc(0, 1, 0, 1, p, 24'h123456, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        idle(1, 0, 1);
        chk("lit_tx_nowrite", 32'(writes_seen), 32'd0);
        chk("lit_fid_1", 32'(o_frame_id), 32'd1);
        chk("lit_grant_off", 32'(o_tx_grant), 32'd0);

        // Short frame: the pixel coincident with vsync is dropped.
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        writes_seen = 0;
        for (int p = 0; p < 10; p++) cyc(0, 1, 0, 1, p, p * 3, 0, 0);
        cyc(0, 1, 1, 1, 10, 24'hABCDEF, 0, 0);
        idle(1, 1, 1);
        chk("lit_short_writes", 32'(writes_seen), 32'd10);
        chk("lit_short_flag", 32'(o_short), 32'd1);

        // Handoff with arm dropped: returns to idle.
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        idle(0, 0, 1);
        chk("lit_fid_2", 32'(o_frame_id), 32'd2);

        // Out-of-range address, sticky across frames.
        idle(1, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        writes_seen = 0;
        cyc(0, 1, 0, 1, FP, 24'h777777, 0, 0);
        idle(1, 0, 1);
        chk("lit_err_set", 32'(o_addr_err), 32'd1);
        chk("lit_err_nowrite", 32'(writes_seen), 32'd0);
        for (int p = 0; p < 5; p++) cyc(0, 1, 0, 1, p, p, 0, 0);

        // Reset mid-capture with vsync held high: no restart until a fresh edge.
        cyc(1, 1, 1, 0, 0, 0, 0, 0);
        writes_seen = 0;
        for (int p = 0; p < 10; p++) cyc(0, 1, 1, 1, p, p, 0, 0);
        chk("lit_rst_nowrite", 32'(writes_seen), 32'd0);
        chk("lit_rst_err", 32'(o_addr_err), 32'd0);
        chk("lit_rst_fid", 32'(o_frame_id), 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        for (int p = 0; p < 3; p++) cyc(0, 1, 1, 1, p, p, 0, 0);
        idle(1, 1, 1);
        chk("lit_rst_restart", 32'(writes_seen), 32'd3);

        // Buffer held across three vsync edges.
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 1, 0);
        for (int r = 0; r < 2; r++) begin
            cyc(0, 1, 0, 0, 0, 0, 0, 0);
            cyc(0, 1, 1, 0, 0, 0, 0, 0);
        end
        idle(1, 1, 1);
        chk("lit_held_grant", 32'(o_tx_grant), 32'd1);
`ifdef FRAME_CAPTURE_DROP_CNT_EN
        chk("lit_drop_3", 32'(o_drop_cnt), 32'd3);
`endif
        cyc(0, 1, 0, 0, 0, 0, 0, 1);

        // Randomized run.
        vs_lvl  = 1'b0;
        arm_lvl = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            bit rst;
            int unsigned addr;
            if ($urandom_range(0, 39) == 0) vs_lvl = !vs_lvl;
            if ($urandom_range(0, 199) == 0) arm_lvl = !arm_lvl;
            rst  = ($urandom_range(0, 599) == 0);
            addr = ($urandom_range(0, 19) == 0) ? FP + $urandom_range(0, 200)
                                                : $urandom_range(0, FP - 1);
            cyc(rst, arm_lvl, vs_lvl, $urandom_range(0, 3) != 0, addr,
                $urandom & 24'hFFFFFF, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        end
        idle(1, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
